// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream and memory-write signal bundle for prog_loader.
//   in_valid / in_data  : byte source -> loader
//   in_ready            : loader -> byte source
//   mem_we / mem_addr / mem_wdata : loader -> program memory write port
// Modports:
//   slave  : the loader's view (consumes the byte stream, drives the write port)
//   master : the environment's view (byte source plus memory write sink)
interface prog_loader_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the SAP-1 program memory.
// Accepts DEPTH bytes over a valid/ready handshake, writes them to
// consecutive addresses from 0 with one cycle of write latency, and holds
// the CPU in reset while a session is in progress.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin a load session (honoured in IDLE or DONE only)
//   bus      : prog_loader_if.slave (in_valid/in_data/in_ready byte stream,
//              mem_we/mem_addr/mem_wdata memory write port)
//   cpu_hold : CPU reset request, high while loading
//   done     : last session completed
//   err      : checksum mismatch on the last session
//
// Build option: define LOADER_CHECKSUM_EN to append a checksum byte
// (8-bit modulo sum of the data bytes) to each session; without it err is 0.
module prog_loader #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t state_q, state_d;

  // One extra bit so the counter can reach DEPTH without wrapping.
  logic [AW:0] cnt_q;
  logic        last_word;
  logic        accept_load;
  logic        start_ok;

  assign last_word   = (cnt_q == (AW+1)'(DEPTH-1));
  assign accept_load = (state_q == LOAD) && bus.in_valid;
  assign start_ok    = ((state_q == IDLE) || (state_q == DONE)) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (accept_load && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (bus.in_valid) state_d = DONE;
`endif
      DONE: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.in_ready = 1'b0;
    cpu_hold     = 1'b0;
    done         = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Write port and address counter; mem_addr/mem_wdata hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (start_ok) cnt_q <= '0;
      if (accept_load) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= cnt_q[AW-1:0];
        bus.mem_wdata <= bus.in_data;
        cnt_q         <= cnt_q + (AW+1)'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      err   <= 1'b0;
    end else begin
      if (start_ok) begin
        sum_q <= '0;
        err   <= 1'b0;
      end
      if (accept_load) sum_q <= sum_q + bus.in_data;
      if ((state_q == CHECK) && bus.in_valid) err <= (bus.in_data != sum_q);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, done, err;

  prog_loader_if #(.DW(DW), .AW(AW)) bus ();

  prog_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } wr_t;

  wr_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0h data %0h expected no write (cycle %0d)",
                 bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr",  32'(bus.mem_addr),  32'(e.addr));
        check("wr_data",  32'(bus.mem_wdata), 32'(e.data));
        check("wr_cycle", cyc,                e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input int unsigned a);
    wr_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    check("in_ready_load", 32'(bus.in_ready), 32'd1);
    check("cpu_hold_load", 32'(cpu_hold), 32'd1);
    e.addr = AW'(a);
    e.data = d;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    step();
  endtask

  task automatic load_session(input logic [DW-1:0] base, input logic [DW-1:0] inc,
                              input bit stall, input bit bad_sum);
    logic [DW-1:0] sum;
    logic [DW-1:0] d;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_ready", 32'(bus.in_ready), 32'd1);
    check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr",  32'(err), 32'd0);
    sum = '0;
    d   = base;
    for (int i = 0; i < DEPTH; i++) begin
      if (stall && (i % 4 == 2)) begin
        bus.in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("stall_in_ready", 32'(bus.in_ready), 32'd1);
      end
      send(d, i);
      sum = sum + d;
      d   = d + inc;
    end
    d = d - inc;
`ifdef LOADER_CHECKSUM_EN
    bus.in_valid = 1'b1;
    bus.in_data  = bad_sum ? sum + 8'd1 : sum;
    check("csum_in_ready", 32'(bus.in_ready), 32'd1);
    check("csum_not_done", 32'(done), 32'd0);
    step();
`endif
    bus.in_valid = 1'b0;
    check("end_done",     32'(done), 32'd1);
    check("end_cpu_hold", 32'(cpu_hold), 32'd0);
    check("end_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("end_err", 32'(err), 32'(bad_sum));
`else
    check("end_err", 32'(err), 32'd0);
`endif
    step();
    check("drained",   sb.size(), 32'd0);
    check("hold_addr", 32'(bus.mem_addr), 32'(DEPTH-1));
    check("hold_data", 32'(bus.mem_wdata), 32'(d));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we), 32'd0);
    check("rst_addr",     32'(bus.mem_addr), 32'd0);
    check("rst_wdata",    32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_err",      32'(err), 32'd0);
    rst = 1'b0;
    start = 1'b0;

    // Bytes offered in IDLE are not taken.
    bus.in_data = 8'h55;
    step();
    step();
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    check("idle_cpu_hold", 32'(cpu_hold), 32'd0);
    bus.in_valid = 1'b0;

    // Full continuous load, then a restart from DONE with stalls and start pulses.
    load_session(8'h10, 8'h01, 1'b0, 1'b0);
    load_session(8'hA0, 8'h01, 1'b1, 1'b0);

    // Reset mid-session.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), i);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("mid_rst_done",     32'(done), 32'd0);
    check("mid_rst_addr",     32'(bus.mem_addr), 32'd0);
    step();
    check("mid_rst_drained", sb.size(), 32'd0);
    load_session(8'h30, 8'h03, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    load_session(8'h01, 8'h00, 1'b0, 1'b0);
    load_session(8'h01, 8'h00, 1'b0, 1'b1);
    load_session(8'h01, 8'h00, 1'b0, 1'b0);
`endif

    step();
    check("final_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
